// File: rtl/bcd_conv_sched.sv
// Shared iterative binary-to-BCD converter (double-dabble, one shift per clock)
// serving two requesters through a round-robin arbiter with valid/ready handshakes.
module bcd_conv_sched #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [WIDTH-1:0]      req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [WIDTH-1:0]      req1_data,
    output logic                  req1_ready,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_id,
    input  logic                  out_ready,
    output logic                  busy
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]          state;
    logic [BW-1:0]       bcd;
    logic [WIDTH-1:0]    bin;
    logic [CW-1:0]       cnt;
    logic                rr;
    logic                id;
    logic                grant1;
    logic [BW-1:0]       bcd_adj;
    logic [BW+WIDTH-1:0] shifted;

    // Requester 1 wins when it is alone or when the pointer favours it.
    always_comb begin
        grant1     = req1_valid && (!req0_valid || rr);
        req0_ready = (state == IDLE) && req0_valid && !grant1;
        req1_ready = (state == IDLE) && grant1;
    end

    always_comb begin
        bcd_adj = bcd;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
        shifted = {bcd_adj, bin} << 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            bcd   <= '0;
            bin   <= '0;
            cnt   <= '0;
            rr    <= 1'b0;
            id    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        bcd   <= '0;
                        bin   <= req1_ready ? req1_data : req0_data;
                        id    <= req1_ready;
                        rr    <= ~req1_ready;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd, bin} <= shifted;
                    cnt        <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid = (state == DONE);
    assign out_bcd   = bcd;
    assign out_id    = id;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed self-checking bench for bcd_conv_sched (WIDTH=8, DIGITS=3).
module tb_bcd_conv_sched;
    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [7:0]  req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [7:0]  req1_data;
    logic        req1_ready;
    logic        out_valid;
    logic [11:0] out_bcd;
    logic        out_id;
    logic        out_ready;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [11:0] res_bcd [16];
    logic        res_id  [16];
    int          n_res;
    int          acc_first [2];

    bcd_conv_sched #(.WIDTH(8), .DIGITS(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_bcd    (out_bcd),
        .out_id     (out_id),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst        = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [11:0] dec_ref(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic digits_ok(input logic [11:0] b);
        return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) && (b[11:8] <= 4'd9);
    endfunction

    // Single request on one port; checks latency, result, owner and digit range.
    task automatic do_conv(input logic which, input logic [7:0] v, input logic [11:0] exp, input string tag);
        int k;
        if (which) begin req1_valid = 1'b1; req1_data = v; end
        else       begin req0_valid = 1'b1; req0_data = v; end
        #1;
        k = 0;
        while (!(which ? req1_ready : req0_ready) && k < 20) begin
            step();
            k++;
        end
        check({tag, "_accept"}, 32'(k < 20), 32'd1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            step();
            k++;
        end
        check({tag, "_latency"}, 32'(k), 32'd8);
        check({tag, "_bcd"}, 32'(out_bcd), 32'(exp));
        check({tag, "_id"}, 32'(out_id), 32'(which));
        check({tag, "_digits"}, 32'(digits_ok(out_bcd)), 32'd1);
        step();
    endtask

    // Runs with the currently driven valids until n results appear; keep holds valids high.
    task automatic collect(input int n, input bit keep);
        bit g0, g1;
        n_res = 0;
        acc_first[0] = -1;
        acc_first[1] = -1;
        #1;
        for (int c = 0; c < 300 && n_res < n; c++) begin
            g0 = req0_valid && req0_ready;
            g1 = req1_valid && req1_ready;
            if (out_valid && out_ready) begin
                res_bcd[n_res] = out_bcd;
                res_id[n_res]  = out_id;
                n_res++;
            end
            step();
            if (g0) begin
                if (acc_first[0] < 0) acc_first[0] = c;
                if (!keep) req0_valid = 1'b0;
            end
            if (g1) begin
                if (acc_first[1] < 0) acc_first[1] = c;
                if (!keep) req1_valid = 1'b0;
            end
        end
        check("collect_count", 32'(n_res), 32'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = '0;
        req1_data  = '0;
        out_ready  = 1'b1;
        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_bcd", 32'(out_bcd), 32'd0);
        check("rst_id", 32'(out_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        step();
        rst = 1'b0;
        step();

        do_conv(1'b0, 8'hAA, 12'h170, "aa");
        do_conv(1'b0, 8'hFF, 12'h255, "ff");
        do_conv(1'b0, 8'h00, 12'h000, "00");
        do_conv(1'b0, 8'h0F, 12'h015, "0f");

        // Contention straight out of reset.
        rst = 1'b1;
        step();
        req0_valid = 1'b1; req0_data = 8'h55;
        req1_valid = 1'b1; req1_data = 8'hF0;
        rst = 1'b0;
        #1;
        check("cont_ungranted_ready", 32'(req1_ready), 32'd0);
        check("cont_granted_ready", 32'(req0_ready), 32'd1);
        collect(2, 1'b0);
        check("cont_first_bcd", 32'(res_bcd[0]), 32'h085);
        check("cont_first_id", 32'(res_id[0]), 32'd0);
        check("cont_second_bcd", 32'(res_bcd[1]), 32'h240);
        check("cont_second_id", 32'(res_id[1]), 32'd1);
        check("cont_accept_gap", 32'(acc_first[1] - acc_first[0]), 32'd10);

        // Fairness with both valid continuously.
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h10;
        req1_valid = 1'b1; req1_data = 8'h20;
        collect(6, 1'b1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("fair_id%0d", i), 32'(res_id[i]), 32'(i % 2));
            check($sformatf("fair_bcd%0d", i), 32'(res_bcd[i]), (i % 2) ? 32'h032 : 32'h016);
        end

        // req1 alone leaves the pointer on req0.
        step();
        do_conv(1'b1, 8'h07, 12'h007, "r1_alone");
        req0_valid = 1'b1; req0_data = 8'h09;
        req1_valid = 1'b1; req1_data = 8'h63;
        collect(1, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("after_r1_id", 32'(res_id[0]), 32'd0);
        check("after_r1_bcd", 32'(res_bcd[0]), 32'h009);

        // Back-pressure in DONE.
        do_reset();
        out_ready  = 1'b0;
        req0_valid = 1'b1; req0_data = 8'hCC;
        #1;
        k = 0;
        while (!req0_ready && k < 20) begin step(); k++; end
        check("bp_accept", 32'(k < 20), 32'd1);
        step();
        req0_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin step(); k++; end
        check("bp_latency", 32'(k), 32'd8);
        req1_valid = 1'b1; req1_data = 8'h01;
        #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_bcd%0d", i), 32'(out_bcd), 32'h204);
            check($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("bp_id%0d", i), 32'(out_id), 32'd0);
            check($sformatf("bp_noready%0d", i), 32'({req0_ready, req1_ready}), 32'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_still_valid", 32'(out_valid), 32'd1);
        step();
        check("bp_idle_valid", 32'(out_valid), 32'd0);
        check("bp_idle_busy", 32'(busy), 32'd0);
        check("bp_idle_ready", 32'(req1_ready), 32'd1);
        req1_valid = 1'b0;

        // Reset in the middle of SHIFT.
        do_reset();
        req0_valid = 1'b1; req0_data = 8'hB6;
        #1;
        k = 0;
        while (!req0_ready && k < 20) begin step(); k++; end
        step();
        req0_valid = 1'b0;
        step();
        step();
        step();
        check("mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_bcd", 32'(out_bcd), 32'd0);
        step();
        rst = 1'b0;
        req0_valid = 1'b1; req0_data = 8'h33;
        req1_valid = 1'b1; req1_data = 8'h33;
        collect(1, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("mid_next_bcd", 32'(res_bcd[0]), 32'h051);
        check("mid_next_id", 32'(res_id[0]), 32'd0);

        // Exhaustive sweep alternating requesters.
        do_reset();
        for (int v = 0; v < 256; v++) begin
            do_conv(1'(v % 2), 8'(v), dec_ref(v), $sformatf("sweep%0d", v));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
